// File: rtl/sampletest_hs_if.sv
// Handshaked triangle/sample input bundle and hit/color output bundle for sampletest_hs.
// The master modport belongs to the upstream driver; slave is the pipeline side.
interface sampletest_hs_if #(
    parameter int SIGFIG = 24,
    parameter int COLORS = 3
);
    logic                           in_valid;
    logic                           in_ready;
    logic [2:0][2:0][SIGFIG-1:0]    tri_in;
    logic [COLORS-1:0][SIGFIG-1:0]  color_in;
    logic [1:0][SIGFIG-1:0]         sample_in;
    logic                           cull_en;
    logic                           out_valid;
    logic                           out_ready;
    logic [2:0][SIGFIG-1:0]         hit_out;
    logic [COLORS-1:0][SIGFIG-1:0]  color_out;
    logic                           hit_flag;

    modport master (
        output in_valid, tri_in, color_in, sample_in, cull_en, out_ready,
        input  in_ready, out_valid, hit_out, color_out, hit_flag
    );

    modport slave (
        input  in_valid, tri_in, color_in, sample_in, cull_en, out_ready,
        output in_ready, out_valid, hit_out, color_out, hit_flag
    );
endinterface

// File: rtl/sampletest_hs.sv
// Three-stage stallable sample-test pipeline: edge functions, fill rule, optional backface
// culling, valid/ready output and saturating sample/hit counters.
module sampletest_hs #(
    parameter int         SIGFIG     = 24,
    parameter int         RADIX      = 10,
    parameter int         COLORS     = 3,
    parameter int         TRUNCFRONT = 8,
    parameter logic [2:0] EDGE_INCL  = 3'b101,
    parameter bit         DROP_MISS  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    sampletest_hs_if.slave     bus,
    input  logic               cnt_clr,
    output logic [31:0]        sample_cnt,
    output logic [31:0]        hit_cnt
);
    localparam int W  = SIGFIG - TRUNCFRONT;
    localparam int W2 = 2 * W;
    localparam int unused_radix = RADIX;

    function automatic logic signed [W-1:0] trunc_coord(input logic [SIGFIG-1:0] v);
        return {v[SIGFIG-1], v[SIGFIG-2-TRUNCFRONT:0]};
    endfunction

    function automatic logic signed [W2-1:0] edge_dist(input logic signed [W-1:0] ax, ay, bx, by);
        logic signed [W2-1:0] p;
        logic signed [W2-1:0] q;
        p = W2'(ax) * W2'(by);
        q = W2'(bx) * W2'(ay);
        return p - q;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic                           vld_p1_q, vld_p1_d;
    logic [2:0][SIGFIG-1:0]         dx_p1_q, dx_p1_d, dy_p1_q, dy_p1_d;
    logic [SIGFIG-1:0]              z0_p1_q, z0_p1_d;
    logic [1:0][SIGFIG-1:0]         smp_p1_q, smp_p1_d;
    logic [COLORS-1:0][SIGFIG-1:0]  col_p1_q, col_p1_d;
    logic                           cull_p1_q, cull_p1_d;

    logic                           vld_p2_q, vld_p2_d;
    logic [2:0][W2-1:0]             dist_p2_q, dist_p2_d;
    logic [SIGFIG-1:0]              z0_p2_q, z0_p2_d;
    logic [1:0][SIGFIG-1:0]         smp_p2_q, smp_p2_d;
    logic [COLORS-1:0][SIGFIG-1:0]  col_p2_q, col_p2_d;
    logic                           cull_p2_q, cull_p2_d;

    logic                           vld_p3_q, vld_p3_d;
    logic                           hit_p3_q, hit_p3_d;
    logic [2:0][SIGFIG-1:0]         hout_p3_q, hout_p3_d;
    logic [COLORS-1:0][SIGFIG-1:0]  col_p3_q, col_p3_d;

    logic [31:0]                    sample_cnt_q, sample_cnt_d, hit_cnt_q, hit_cnt_d;

    logic rdy_p1, rdy_p2, rdy_p3, in_fire, hit_fire, hit_c;
    logic [2:0] neg_e, pos_e, zero_e;
    logic unused_z;

    assign unused_z = ^{bus.tri_in[1][2], bus.tri_in[2][2]};

    always_comb begin
        // A miss is allowed to leave S3 without a handshake when misses are dropped.
        rdy_p3   = !vld_p3_q || bus.out_ready || (DROP_MISS && !hit_p3_q);
        rdy_p2   = !vld_p2_q || rdy_p3;
        rdy_p1   = !vld_p1_q || rdy_p2;
        in_fire  = bus.in_valid && rdy_p1;
        hit_fire = bus.out_valid && bus.out_ready && hit_p3_q;

        // Stage 1: vertices relative to the sample
        vld_p1_d  = rdy_p1 ? bus.in_valid : vld_p1_q;
        dx_p1_d   = dx_p1_q;
        dy_p1_d   = dy_p1_q;
        z0_p1_d   = z0_p1_q;
        smp_p1_d  = smp_p1_q;
        col_p1_d  = col_p1_q;
        cull_p1_d = cull_p1_q;
        if (in_fire) begin
            for (int i = 0; i < 3; i++) begin
                dx_p1_d[i] = bus.tri_in[i][0] - bus.sample_in[0];
                dy_p1_d[i] = bus.tri_in[i][1] - bus.sample_in[1];
            end
            z0_p1_d   = bus.tri_in[0][2];
            smp_p1_d  = bus.sample_in;
            col_p1_d  = bus.color_in;
            cull_p1_d = bus.cull_en;
        end

        // Stage 2: truncated edge functions
        vld_p2_d  = rdy_p2 ? vld_p1_q : vld_p2_q;
        dist_p2_d = dist_p2_q;
        z0_p2_d   = z0_p2_q;
        smp_p2_d  = smp_p2_q;
        col_p2_d  = col_p2_q;
        cull_p2_d = cull_p2_q;
        if (vld_p1_q && rdy_p2) begin
            for (int e = 0; e < 3; e++) begin
                dist_p2_d[e] = edge_dist(trunc_coord(dx_p1_q[e]), trunc_coord(dy_p1_q[e]),
                                         trunc_coord(dx_p1_q[(e == 2) ? 0 : e + 1]),
                                         trunc_coord(dy_p1_q[(e == 2) ? 0 : e + 1]));
            end
            z0_p2_d   = z0_p1_q;
            smp_p2_d  = smp_p1_q;
            col_p2_d  = col_p1_q;
            cull_p2_d = cull_p1_q;
        end

        // Stage 3: fill rule and winding decision
        for (int e = 0; e < 3; e++) begin
            zero_e[e] = (dist_p2_q[e] == '0);
            neg_e[e]  = dist_p2_q[e][W2-1] || (EDGE_INCL[e] && zero_e[e]);
            pos_e[e]  = (!dist_p2_q[e][W2-1] && !zero_e[e]) || (EDGE_INCL[e] && zero_e[e]);
        end
        hit_c = !(&zero_e) && ((&neg_e) || (!cull_p2_q && (&pos_e)));

        vld_p3_d  = rdy_p3 ? vld_p2_q : vld_p3_q;
        hit_p3_d  = hit_p3_q;
        hout_p3_d = hout_p3_q;
        col_p3_d  = col_p3_q;
        if (vld_p2_q && rdy_p3) begin
            hit_p3_d  = hit_c;
            hout_p3_d = {z0_p2_q, smp_p2_q[1], smp_p2_q[0]};
            col_p3_d  = col_p2_q;
        end

        sample_cnt_d = cnt_clr ? '0 : (in_fire  ? sat_inc(sample_cnt_q) : sample_cnt_q);
        hit_cnt_d    = cnt_clr ? '0 : (hit_fire ? sat_inc(hit_cnt_q)    : hit_cnt_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q <= 1'b0; dx_p1_q <= '0; dy_p1_q <= '0; z0_p1_q <= '0;
            smp_p1_q <= '0;   col_p1_q <= '0; cull_p1_q <= 1'b0;
            vld_p2_q <= 1'b0; dist_p2_q <= '0; z0_p2_q <= '0;
            smp_p2_q <= '0;   col_p2_q <= '0; cull_p2_q <= 1'b0;
            vld_p3_q <= 1'b0; hit_p3_q <= 1'b0; hout_p3_q <= '0; col_p3_q <= '0;
            sample_cnt_q <= '0; hit_cnt_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d; dx_p1_q <= dx_p1_d; dy_p1_q <= dy_p1_d; z0_p1_q <= z0_p1_d;
            smp_p1_q <= smp_p1_d; col_p1_q <= col_p1_d; cull_p1_q <= cull_p1_d;
            vld_p2_q <= vld_p2_d; dist_p2_q <= dist_p2_d; z0_p2_q <= z0_p2_d;
            smp_p2_q <= smp_p2_d; col_p2_q <= col_p2_d; cull_p2_q <= cull_p2_d;
            vld_p3_q <= vld_p3_d; hit_p3_q <= hit_p3_d; hout_p3_q <= hout_p3_d; col_p3_q <= col_p3_d;
            sample_cnt_q <= sample_cnt_d; hit_cnt_q <= hit_cnt_d;
        end
    end

    assign bus.in_ready  = rdy_p1;
    assign bus.out_valid = vld_p3_q && (hit_p3_q || !DROP_MISS);
    assign bus.hit_flag  = hit_p3_q;
    assign bus.hit_out   = hout_p3_q;
    assign bus.color_out = col_p3_q;
    assign sample_cnt    = sample_cnt_q;
    assign hit_cnt       = hit_cnt_q;
endmodule

// File: tb/tb_sampletest_hs.sv
// Directed bench for sampletest_hs: one instance keeping misses, one dropping them.
module tb_sampletest_hs;
    localparam int SF = 24;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0][2:0][SF-1:0]  tri_v;
    logic [NC-1:0][SF-1:0]    col_v;
    logic [1:0][SF-1:0]       smp_v;
    logic                     cull_v;
    logic                     va, vd, ra, rd, clr_a, clr_d;
    logic [31:0]              scnt_a, hcnt_a, scnt_d, hcnt_d;
    int                       errors = 0;
    int                       checks = 0;

    sampletest_hs_if #(.SIGFIG(SF), .COLORS(NC)) ifa ();
    sampletest_hs_if #(.SIGFIG(SF), .COLORS(NC)) ifd ();

    assign ifa.in_valid = va;     assign ifd.in_valid = vd;
    assign ifa.out_ready = ra;    assign ifd.out_ready = rd;
    assign ifa.tri_in = tri_v;    assign ifd.tri_in = tri_v;
    assign ifa.color_in = col_v;  assign ifd.color_in = col_v;
    assign ifa.sample_in = smp_v; assign ifd.sample_in = smp_v;
    assign ifa.cull_en = cull_v;  assign ifd.cull_en = cull_v;

    sampletest_hs #(.SIGFIG(SF), .COLORS(NC), .DROP_MISS(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(ifa.slave), .cnt_clr(clr_a),
        .sample_cnt(scnt_a), .hit_cnt(hcnt_a));

    sampletest_hs #(.SIGFIG(SF), .COLORS(NC), .DROP_MISS(1'b1)) dut_drop (
        .clk(clk), .rst(rst), .bus(ifd.slave), .cnt_clr(clr_d),
        .sample_cnt(scnt_d), .hit_cnt(hcnt_d));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int x0, y0, x1, y1, x2, y2, z0, sx, sy, input logic cull);
        tri_v = '0;
        tri_v[0][0] = 24'(x0); tri_v[0][1] = 24'(y0); tri_v[0][2] = 24'(z0);
        tri_v[1][0] = 24'(x1); tri_v[1][1] = 24'(y1);
        tri_v[2][0] = 24'(x2); tri_v[2][1] = 24'(y2);
        col_v[0] = 24'(z0 * 3); col_v[1] = 24'(z0 + 100); col_v[2] = 24'hABCDEF;
        smp_v[0] = 24'(sx); smp_v[1] = 24'(sy);
        cull_v = cull;
    endtask

    // Clockwise reference triangle (0,0),(0,4096),(4096,0)
    task automatic tri_a(input int sx, sy, z, input logic cull);
        set_in(0, 0, 0, 4096, 4096, 0, z, sx, sy, cull);
    endtask

    // Called at a negedge with inputs already set and an empty pipeline.
    task automatic send_one(input string tag, input int sx, sy, z, input logic exp_hit);
        int n;
        n = 0;
        va = 1'b1;
        @(negedge clk);
        va = 1'b0;
        while (ifa.out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd2);
        check({tag, "_hit"}, 64'(ifa.hit_flag), 64'(exp_hit));
        check({tag, "_x"}, 64'(ifa.hit_out[0]), 64'(sx));
        check({tag, "_y"}, 64'(ifa.hit_out[1]), 64'(sy));
        check({tag, "_z"}, 64'(ifa.hit_out[2]), 64'(z));
        check({tag, "_col"}, 64'({ifa.color_out[2], ifa.color_out[1], ifa.color_out[0]}),
              64'({24'hABCDEF, 24'(z + 100), 24'(z * 3)}));
        @(negedge clk);
    endtask

    initial begin
        int acc, got, c, low_at;
        logic stall_prev;
        logic [2:0][SF-1:0] ho_prev;

        rst = 1'b0; va = 1'b0; vd = 1'b0; ra = 1'b1; rd = 1'b1; clr_a = 1'b0; clr_d = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_hit_flag", 64'(ifa.hit_flag), 64'd0);
        check("rst_cnts", 64'({scnt_a, hcnt_a}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(ifa.in_ready), 64'd1);

        // Winding, culling and fill-rule vectors
        tri_a(1024, 1024, 77, 1'b1);              send_one("cw_cull", 1024, 1024, 77, 1'b1);
        check("cw_hit_cnt", 64'(hcnt_a), 64'd1);
        set_in(0, 0, 4096, 0, 0, 4096, 20, 1024, 1024, 1'b1);
        send_one("ccw_cull", 1024, 1024, 20, 1'b0);
        set_in(0, 0, 4096, 0, 0, 4096, 21, 1024, 1024, 1'b0);
        send_one("ccw_nocull", 1024, 1024, 21, 1'b1);
        tri_a(0, 1024, 22, 1'b1);                 send_one("on_e0", 0, 1024, 22, 1'b1);
        tri_a(2048, 2048, 23, 1'b1);              send_one("on_e1", 2048, 2048, 23, 1'b0);
        set_in(5, 5, 5, 5, 5, 5, 24, 5, 5, 1'b0); send_one("degen", 5, 5, 24, 1'b0);
        check("seq_sample_cnt", 64'(scnt_a), 64'd6);
        check("seq_hit_cnt", 64'(hcnt_a), 64'd3);

        // Backpressure: eight inputs back to back, out_ready low for cycles 2..7
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("clr_sample_cnt", 64'(scnt_a), 64'd0);
        acc = 0; got = 0; c = 0; low_at = -1; stall_prev = 1'b0; ho_prev = '0;
        while (got < 8 && c < 60) begin
            ra = !(c >= 2 && c <= 7);
            if (acc < 8) begin
                tri_a(100 + acc * 10, 1000, acc + 1, 1'b1);
                va = 1'b1;
            end else begin
                va = 1'b0;
            end
            #1;
            if (stall_prev) begin
                check("bp_hold_z", 64'(ifa.hit_out[2]), 64'(ho_prev[2]));
                check("bp_hold_x", 64'(ifa.hit_out[0]), 64'(ho_prev[0]));
            end
            if (va && !ifa.in_ready && low_at < 0) begin
                low_at = c;
                check("bp_full_after", 64'(acc), 64'd3);
            end
            if (c == 8) check("bp_ready_release", 64'(ifa.in_ready), 64'd1);
            if (ifa.out_valid && ra) begin
                check("bp_order", 64'(ifa.hit_out[2]), 64'(got + 1));
                got++;
            end
            stall_prev = ifa.out_valid && !ra;
            ho_prev = ifa.hit_out;
            if (va && ifa.in_ready) acc++;
            @(negedge clk);
            c++;
        end
        va = 1'b0; ra = 1'b1;
        check("bp_out_count", 64'(got), 64'd8);
        check("bp_full_seen", 64'(low_at), 64'd3);
        check("bp_sample_cnt", 64'(scnt_a), 64'd8);
        check("bp_hit_cnt", 64'(hcnt_a), 64'd8);

        // DROP_MISS instance: alternating hit/miss stream of six
        acc = 0; got = 0;
        for (int k = 0; k < 30; k++) begin
            if (acc < 6) begin
                if (acc % 2 == 0) tri_a(1024, 1024, acc + 1, 1'b1);
                else              tri_a(3000, 3000, acc + 1, 1'b1);
                vd = 1'b1;
            end else begin
                vd = 1'b0;
            end
            #1;
            if (ifd.out_valid) begin
                check("drop_hit_flag", 64'(ifd.hit_flag), 64'd1);
                check("drop_tag", 64'(ifd.hit_out[2]), 64'(2 * got + 1));
                check("drop_xy", 64'({ifd.hit_out[1], ifd.hit_out[0]}), 64'({24'd1024, 24'd1024}));
                check("drop_col", 64'({ifd.color_out[2], ifd.color_out[1], ifd.color_out[0]}),
                      64'({24'hABCDEF, 24'(2 * got + 101), 24'(6 * got + 3)}));
                got++;
            end
            if (vd && ifd.in_ready) acc++;
            @(negedge clk);
        end
        vd = 1'b0;
        check("drop_out_count", 64'(got), 64'd3);
        check("drop_sample_cnt", 64'(scnt_d), 64'd6);
        check("drop_hit_cnt", 64'(hcnt_d), 64'd3);

        // Reset with two pairs in flight
        ra = 1'b0;
        tri_a(1024, 1024, 50, 1'b1); va = 1'b1;
        @(negedge clk);
        tri_a(1024, 1024, 51, 1'b1);
        @(negedge clk);
        va = 1'b0;
        @(negedge clk);
        check("midrst_pre_valid", 64'(ifa.out_valid), 64'd1);
        #2 rst = 1'b0;
        #1 check("midrst_valid_now", 64'(ifa.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1; ra = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifa.out_valid) got++;
        end
        check("midrst_no_output", 64'(got), 64'd0);
        check("midrst_in_ready", 64'(ifa.in_ready), 64'd1);
        check("midrst_cnts", 64'({scnt_a, hcnt_a}), 64'd0);

        // Saturation from a preloaded sample counter
        force dut.sample_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.sample_cnt_q;
        check("sat_preload", 64'(scnt_a), 64'hFFFF_FFFE);
        tri_a(1024, 1024, 60, 1'b1); va = 1'b1;
        repeat (3) @(negedge clk);
        va = 1'b0;
        check("sat_sample_cnt", 64'(scnt_a), 64'hFFFF_FFFF);
        repeat (6) @(negedge clk);

        // Clear wins over a same-cycle accept
        clr_a = 1'b1; va = 1'b1;
        @(negedge clk);
        clr_a = 1'b0; va = 1'b0;
        check("clr_vs_accept", 64'(scnt_a), 64'd0);
        check("clr_hit_cnt", 64'(hcnt_a), 64'd0);
        repeat (6) @(negedge clk);
        check("post_clr_hit_cnt", 64'(hcnt_a), 64'd1);
        check("post_clr_sample_cnt", 64'(scnt_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
